alu_pipe: RTL and testbench

//  Parametrised, 2-stage pipelined successor to the 4-bit combinational ALU.

---
 rtl/alu_pipe.sv | 136 +++++++++++++
 tb/tb_alu_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes, status flags and an accumulator operand source.
// Build option: define ALU_SAT_EN to clamp overflowing arithmetic results to the signed extreme.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  input  logic             Cin,
  input  logic             acc_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             Cout,
  output logic             zero,
  output logic             ovf
);

`ifdef ALU_SAT_EN
  function automatic logic signed [WIDTH-1:0] sat_result(input logic signed [WIDTH-1:0] raw,
                                                         input logic ov, input logic neg);
    if (!ov) return raw;
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  logic                    vld_p1_q, vld_p1_d;
  logic signed [WIDTH-1:0] a_p1_q, b_p1_q;
  logic [2:0]              sel_p1_q;
  logic                    cin_p1_q, accsel_p1_q;

  logic                    vld_p2_q, vld_p2_d;
  logic signed [WIDTH-1:0] word_p2_q, word_p2_d;
  logic                    cout_p2_q, cout_p2_d;
  logic                    zero_p2_q, zero_p2_d;
  logic                    ovf_p2_q, ovf_p2_d;
  logic signed [WIDTH-1:0] acc_q;

  logic                    adv, accept;
  logic signed [WIDTH-1:0] exe_a, bterm, raw;
  logic [WIDTH:0]          sum;

  assign adv      = vld_p1_q && (!vld_p2_q || out_ready);
  assign in_ready = !rst && (!vld_p1_q || adv);
  assign accept   = in_valid && in_ready;

  always_comb begin
    exe_a     = accsel_p1_q ? acc_q : a_p1_q;
    bterm     = '0;
    sum       = '0;
    raw       = '0;
    word_p2_d = '0;
    cout_p2_d = 1'b0;
    ovf_p2_d  = 1'b0;
    if (!sel_p1_q[2]) begin
      unique case (sel_p1_q[1:0])
        2'b00:   bterm = '0;
        2'b01:   bterm = b_p1_q;
        2'b10:   bterm = ~b_p1_q;
        default: bterm = '1;
      endcase
      sum       = {1'b0, exe_a} + {1'b0, bterm} + {{WIDTH{1'b0}}, cin_p1_q};
      raw       = sum[WIDTH-1:0];
      cout_p2_d = sum[WIDTH];
      // Overflow: both summands share a sign that the result does not.
      ovf_p2_d  = (exe_a[WIDTH-1] == bterm[WIDTH-1]) && (raw[WIDTH-1] != exe_a[WIDTH-1]);
`ifdef ALU_SAT_EN
      word_p2_d = sat_result(raw, ovf_p2_d, exe_a[WIDTH-1]);
`else
      word_p2_d = raw;
`endif
    end else begin
      unique case (sel_p1_q[1:0])
        2'b00:   word_p2_d = exe_a | b_p1_q;
        2'b01:   word_p2_d = exe_a ^ b_p1_q;
        2'b10:   word_p2_d = exe_a & b_p1_q;
        default: word_p2_d = ~exe_a;
      endcase
    end
    zero_p2_d = (word_p2_d == '0);
  end

  always_comb begin
    vld_p1_d = vld_p1_q;
    if (accept)   vld_p1_d = 1'b1;
    else if (adv) vld_p1_d = 1'b0;
    vld_p2_d = vld_p2_q;
    if (adv)            vld_p2_d = 1'b1;
    else if (out_ready) vld_p2_d = 1'b0;
  end

  // S1: operand capture
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1_q      <= A;
      b_p1_q      <= B;
      sel_p1_q    <= sel;
      cin_p1_q    <= Cin;
      accsel_p1_q <= acc_sel;
    end
  end

  // S2: result register and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      acc_q     <= '0;
      word_p2_q <= '0;
      cout_p2_q <= 1'b0;
      zero_p2_q <= 1'b0;
      ovf_p2_q  <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      if (adv) begin
        acc_q     <= word_p2_d;
        word_p2_q <= word_p2_d;
        cout_p2_q <= cout_p2_d;
        zero_p2_q <= zero_p2_d;
        ovf_p2_q  <= ovf_p2_d;
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign word_out  = word_p2_q;
  assign Cout      = cout_p2_q;
  assign zero      = zero_p2_q;
  assign ovf       = ovf_p2_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed spec scenarios followed by randomized traffic.
module tb_alu_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, out_ready = 1'b1, Cin = 1'b0, acc_sel = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic [2:0]   sel = '0;
  logic         in_ready, out_valid, Cout, zero, ovf;
  logic [W-1:0] word_out;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] w;
    logic         c;
    logic         z;
    logic         o;
  } exp_t;

  exp_t         q[$];
  int           model_acc = 0;
  logic         stall_prev = 1'b0;
  logic [W+2:0] held = '0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sel(sel), .Cin(Cin), .acc_sel(acc_sel),
    .out_valid(out_valid), .out_ready(out_ready), .word_out(word_out),
    .Cout(Cout), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: integer arithmetic on the op table, signed range test for overflow.
  function automatic exp_t model(input int a, input int b, input int s, input int cin);
    int   mask, half, bt, u, sa, sb, ss, res;
    exp_t e;
    mask = (1 << W) - 1;
    half = 1 << (W - 1);
    e = '0;
    res = 0;
    if (s < 4) begin
      case (s)
        0:       bt = 0;
        1:       bt = b;
        2:       bt = mask - b;
        default: bt = mask;
      endcase
      u   = a + bt + cin;
      sa  = (a >= half) ? a - (1 << W) : a;
      sb  = (bt >= half) ? bt - (1 << W) : bt;
      ss  = sa + sb + cin;
      e.c = (u > mask);
      e.o = (ss >= half) || (ss < -half);
      res = u & mask;
`ifdef ALU_SAT_EN
      if (e.o) res = (ss >= half) ? half - 1 : half;
`endif
    end else begin
      case (s)
        4:       res = a | b;
        5:       res = a ^ b;
        6:       res = a & b;
        default: res = mask - a;
      endcase
    end
    e.w = W'(res);
    e.z = (res == 0);
    return e;
  endfunction

  // Monitor: handshakes seen at the falling edge complete on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (rst) begin
      q.delete();
      model_acc  = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'({word_out, Cout, zero, ovf}), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%0h required=none", word_out);
        end else begin
          e = q.pop_front();
          chk("word", 32'(word_out), 32'(e.w));
          chk("cout", 32'(Cout), 32'(e.c));
          chk("zero", 32'(zero), 32'(e.z));
          chk("ovf", 32'(ovf), 32'(e.o));
        end
      end
      if (in_valid && in_ready) begin
        a = acc_sel ? model_acc : int'(A);
        e = model(a, int'(B), int'(sel), int'(Cin));
        q.push_back(e);
        model_acc = int'(e.w);
      end
      stall_prev = out_valid && !out_ready;
      held       = {word_out, Cout, zero, ovf};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s,
                      input logic c, input logic as);
    A = a; B = b; sel = s; Cin = c; acc_sel = as;
    in_valid = 1'b1;
    wait_accept();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_word", 32'(word_out), 32'd0);
    chk("rst_flags", 32'({Cout, zero, ovf}), 32'd0);
    tick();
    rst = 1'b0;

    // 1: overflow and two-cycle latency
    send(8'h7F, 8'h01, 3'b001, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid", 32'(out_valid), 32'd1);
`ifdef ALU_SAT_EN
    chk("t1_word", 32'(word_out), 32'h7F);
`else
    chk("t1_word", 32'(word_out), 32'h80);
`endif
    chk("t1_ovf", 32'(ovf), 32'd1);
    chk("t1_cout", 32'(Cout), 32'd0);

    // 2: subtract to zero
    send(8'h05, 8'h05, 3'b010, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("t2_word", 32'(word_out), 32'h00);
    chk("t2_cout_zero_ovf", 32'({Cout, zero, ovf}), 32'b110);

    // 3: dependent back-to-back ops through the accumulator
    send(8'h03, 8'h04, 3'b001, 1'b0, 1'b0);
    send(8'h55, 8'h0A, 3'b001, 1'b0, 1'b1);
    @(negedge clk);
    chk("t3_first", 32'(word_out), 32'h07);
    @(negedge clk);
    chk("t3_second_valid", 32'(out_valid), 32'd1);
    chk("t3_second", 32'(word_out), 32'h11);

    // 4: logic ops streamed
    for (int s = 4; s < 8; s++) send(8'hF0, 8'h3C, 3'(s), 1'b1, 1'b0);
    repeat (3) tick();

    // 5: backpressure, two buffered then in_ready low
    out_ready = 1'b0;
    send(8'h10, 8'h01, 3'b001, 1'b0, 1'b0);
    send(8'h20, 8'h02, 3'b001, 1'b0, 1'b0);
    A = 8'h30; B = 8'h03; sel = 3'b001; Cin = 1'b0; acc_sel = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    chk("t5_in_ready_full", 32'(in_ready), 32'd0);
    repeat (3) tick();
    out_ready = 1'b1;
    wait_accept();
    repeat (4) tick();
    chk("t5_drained", 32'(q.size()), 32'd0);

    // 6: reset with two ops in flight
    out_ready = 1'b0;
    send(8'h11, 8'h22, 3'b001, 1'b0, 1'b0);
    send(8'h33, 8'h44, 3'b001, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_in_ready_rst", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_word", 32'(word_out), 32'd0);
    tick();
    out_ready = 1'b1;
    send(8'hAA, 8'h09, 3'b001, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t6_acc_cleared", 32'(word_out), 32'h09);

    // Randomized traffic with random backpressure and occasional reset
    for (int i = 0; i < 600; i++) begin
      A         = W'($urandom);
      B         = W'($urandom);
      sel       = 3'($urandom);
      Cin       = 1'($urandom);
      acc_sel   = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 79) == 0);
      tick();
    end
    in_valid  = 1'b0;
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("final_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
